control_sequencer: RTL and testbench

//  Moore control unit that drives the datapath's control inputs. Fetches an

---
 rtl/control_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_control_sequencer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Moore control unit: fetches an instruction into IR, then steps T0..T5 to run one ALU op.
// Optional CTRL_R0_ZERO_EN: R0 is hard-wired zero, so Rin[0] is never asserted.
module control_sequencer #(
    parameter int OPW   = 5,
    parameter int RSELW = 4,
    parameter int SELW  = 32
) (
    input  logic                    Clock,
    input  logic                    Clear,
    input  logic                    Run,
    input  logic [31:0]             busMuxOut,
    output logic [SELW-1:0]         encIn,
    output logic [(1<<RSELW)-1:0]   Rin,
    output logic                    PCin,
    output logic                    MDRin,
    output logic                    Read,
    output logic                    Yin,
    output logic                    ZLOin,
    output logic                    IncPC,
    output logic                    ADD,
    output logic                    SUB,
    output logic                    AND,
    output logic                    OR,
    output logic                    NOT,
    output logic                    SHR,
    output logic                    SHRA,
    output logic                    SHL,
    output logic                    Halted
);

    localparam int NREG = 1 << RSELW;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_T0   = 3'd1;
    localparam logic [2:0] ST_T1   = 3'd2;
    localparam logic [2:0] ST_T2   = 3'd3;
    localparam logic [2:0] ST_T3   = 3'd4;
    localparam logic [2:0] ST_T4   = 3'd5;
    localparam logic [2:0] ST_T5   = 3'd6;
    localparam logic [2:0] ST_HALT = 3'd7;

    localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPW-1:0] OP_SHR  = 5'b00101;
    localparam logic [OPW-1:0] OP_SHRA = 5'b00110;
    localparam logic [OPW-1:0] OP_SHL  = 5'b00111;
    localparam logic [OPW-1:0] OP_AND  = 5'b01001;
    localparam logic [OPW-1:0] OP_OR   = 5'b01010;
    localparam logic [OPW-1:0] OP_NOT  = 5'b10010;
    localparam logic [OPW-1:0] OP_HALT = 5'b11011;

    localparam int ENC_ZLO = 19;
    localparam int ENC_PC  = 20;
    localparam int ENC_MDR = 21;

    logic [2:0]       state_q, state_d;
    logic [31:0]      ir_q, ir_d;

    logic [OPW-1:0]   opcode;
    logic [RSELW-1:0] ra, rb, rc;
    logic             is_alu3, is_not, is_halt;
    logic [7:0]       alu_sel;
    logic [NREG-1:0]  rin_sel;
    logic             unused_ir_low;

    assign opcode = ir_q[31 -: OPW];
    assign ra     = ir_q[31-OPW -: RSELW];
    assign rb     = ir_q[31-OPW-RSELW -: RSELW];
    assign rc     = ir_q[31-OPW-2*RSELW -: RSELW];

    // Immediate/address bits are carried in IR but unused by register-register ops.
    assign unused_ir_low = ^ir_q[31-OPW-3*RSELW:0];

    // alu_sel order: {ADD, SUB, AND, OR, NOT, SHR, SHRA, SHL}
    always_comb begin
        is_alu3 = 1'b0;
        is_not  = 1'b0;
        is_halt = 1'b0;
        alu_sel = 8'b0;
        case (opcode)
            OP_ADD:  begin is_alu3 = 1'b1; alu_sel = 8'b1000_0000; end
            OP_SUB:  begin is_alu3 = 1'b1; alu_sel = 8'b0100_0000; end
            OP_AND:  begin is_alu3 = 1'b1; alu_sel = 8'b0010_0000; end
            OP_OR:   begin is_alu3 = 1'b1; alu_sel = 8'b0001_0000; end
            OP_SHR:  begin is_alu3 = 1'b1; alu_sel = 8'b0000_0100; end
            OP_SHRA: begin is_alu3 = 1'b1; alu_sel = 8'b0000_0010; end
            OP_SHL:  begin is_alu3 = 1'b1; alu_sel = 8'b0000_0001; end
            OP_NOT:  is_not  = 1'b1;
            OP_HALT: is_halt = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        rin_sel     = '0;
        rin_sel[ra] = 1'b1;
`ifdef CTRL_R0_ZERO_EN
        rin_sel[0]  = 1'b0;
`endif
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            ST_IDLE: if (Run) state_d = ST_T0;
            ST_T0:   state_d = ST_T1;
            ST_T1:   state_d = ST_T2;
            ST_T2: begin
                ir_d    = busMuxOut;
                state_d = ST_T3;
            end
            ST_T3: begin
                if (is_alu3)      state_d = ST_T4;
                else if (is_not)  state_d = ST_T5;
                else if (is_halt) state_d = ST_HALT;
                else              state_d = ST_T0;
            end
            ST_T4:   state_d = ST_T5;
            ST_T5:   state_d = Run ? ST_T0 : ST_IDLE;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state_q <= ST_IDLE;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // Moore outputs: a pure function of state and IR, so Clear zeroes them without a clock edge.
    always_comb begin
        encIn  = '0;
        Rin    = '0;
        PCin   = 1'b0;
        MDRin  = 1'b0;
        Read   = 1'b0;
        Yin    = 1'b0;
        ZLOin  = 1'b0;
        IncPC  = 1'b0;
        ADD    = 1'b0;
        SUB    = 1'b0;
        AND    = 1'b0;
        OR     = 1'b0;
        NOT    = 1'b0;
        SHR    = 1'b0;
        SHRA   = 1'b0;
        SHL    = 1'b0;
        Halted = 1'b0;
        case (state_q)
            ST_T0: begin
                encIn[ENC_PC] = 1'b1;
                IncPC         = 1'b1;
                ZLOin         = 1'b1;
            end
            ST_T1: begin
                encIn[ENC_ZLO] = 1'b1;
                PCin           = 1'b1;
                Read           = 1'b1;
                MDRin          = 1'b1;
            end
            ST_T2: encIn[ENC_MDR] = 1'b1;
            ST_T3: begin
                if (is_alu3) begin
                    encIn[rb] = 1'b1;
                    Yin       = 1'b1;
                end else if (is_not) begin
                    encIn[rb] = 1'b1;
                    NOT       = 1'b1;
                    ZLOin     = 1'b1;
                end
            end
            ST_T4: begin
                encIn[rc] = 1'b1;
                ZLOin     = 1'b1;
                {ADD, SUB, AND, OR, NOT, SHR, SHRA, SHL} = alu_sel;
            end
            ST_T5: begin
                encIn[ENC_ZLO] = 1'b1;
                Rin            = rin_sel;
            end
            ST_HALT: Halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed testbench for control_sequencer: hand-computed per-cycle control words.
module tb_control_sequencer;

    logic        Clock;
    logic        Clear;
    logic        Run;
    logic [31:0] busMuxOut;
    logic [31:0] encIn;
    logic [15:0] Rin;
    logic        PCin, MDRin, Read, Yin, ZLOin, IncPC;
    logic        ADD, SUB, AND, OR, NOT, SHR, SHRA, SHL, Halted;
    logic [14:0] strobes;

    int errCount   = 0;
    int checkCount = 0;

    localparam logic [14:0] S_PCIN  = 15'h4000;
    localparam logic [14:0] S_MDRIN = 15'h2000;
    localparam logic [14:0] S_READ  = 15'h1000;
    localparam logic [14:0] S_YIN   = 15'h0800;
    localparam logic [14:0] S_ZLOIN = 15'h0400;
    localparam logic [14:0] S_INCPC = 15'h0200;
    localparam logic [14:0] S_ADD   = 15'h0100;
    localparam logic [14:0] S_SUB   = 15'h0080;
    localparam logic [14:0] S_NOT   = 15'h0010;
    localparam logic [14:0] S_SHL   = 15'h0002;
    localparam logic [14:0] S_HALT  = 15'h0001;

`ifdef CTRL_R0_ZERO_EN
    localparam logic [15:0] RIN_R0 = 16'h0000;
`else
    localparam logic [15:0] RIN_R0 = 16'h0001;
`endif

    control_sequencer dut (
        .Clock     (Clock),
        .Clear     (Clear),
        .Run       (Run),
        .busMuxOut (busMuxOut),
        .encIn     (encIn),
        .Rin       (Rin),
        .PCin      (PCin),
        .MDRin     (MDRin),
        .Read      (Read),
        .Yin       (Yin),
        .ZLOin     (ZLOin),
        .IncPC     (IncPC),
        .ADD       (ADD),
        .SUB       (SUB),
        .AND       (AND),
        .OR        (OR),
        .NOT       (NOT),
        .SHR       (SHR),
        .SHRA      (SHRA),
        .SHL       (SHL),
        .Halted    (Halted)
    );

    assign strobes = {PCin, MDRin, Read, Yin, ZLOin, IncPC,
                      ADD, SUB, AND, OR, NOT, SHR, SHRA, SHL, Halted};

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%08h, wanted 0x%08h", tag, got, exp);
        end
    endtask

    task automatic expectCycle(input string tag, input logic [31:0] enc,
                               input logic [15:0] rin, input logic [14:0] str);
        checkOutput({tag, ".encIn"}, encIn, enc);
        checkOutput({tag, ".Rin"}, {16'h0, Rin}, {16'h0, rin});
        checkOutput({tag, ".strobes"}, {17'h0, strobes}, {17'h0, str});
    endtask

    task automatic stepCheck(input string tag, input logic [31:0] enc,
                             input logic [15:0] rin, input logic [14:0] str);
        @(negedge Clock);
        expectCycle(tag, enc, rin, str);
    endtask

    task automatic applyStimulus(input string tag, input logic [31:0] bus);
        stepCheck({tag, ".T0"}, 32'h0010_0000, 16'h0, S_INCPC | S_ZLOIN);
        stepCheck({tag, ".T1"}, 32'h0008_0000, 16'h0, S_PCIN | S_READ | S_MDRIN);
        stepCheck({tag, ".T2"}, 32'h0020_0000, 16'h0, 15'h0);
        busMuxOut = bus;
    endtask

    task automatic runAlu3(input string tag, input logic [31:0] bus, input logic [31:0] encRb,
                           input logic [31:0] encRc, input logic [14:0] op, input logic [15:0] rin);
        applyStimulus(tag, bus);
        stepCheck({tag, ".T3"}, encRb, 16'h0, S_YIN);
        stepCheck({tag, ".T4"}, encRc, 16'h0, op | S_ZLOIN);
        stepCheck({tag, ".T5"}, 32'h0008_0000, rin, 15'h0);
    endtask

    initial begin
        Clear     = 1'b0;
        Run       = 1'b1;
        busMuxOut = 32'h0;

        repeat (3) @(posedge Clock);
        @(negedge Clock);
        expectCycle("reset", 32'h0, 16'h0, 15'h0);
        Clear = 1'b1;

        // ADD R3,R1,R2
        runAlu3("add", 32'h1989_0000, 32'h0000_0002, 32'h0000_0004, S_ADD, 16'h0008);

        // NOT R2,R7 goes straight from T3 to T5
        applyStimulus("not", 32'h9138_0000);
        stepCheck("not.T3", 32'h0000_0080, 16'h0, S_NOT | S_ZLOIN);
        stepCheck("not.T5", 32'h0008_0000, 16'h0004, 15'h0);

        // SHL R5,R5,R6
        runAlu3("shl", 32'h3AAB_0000, 32'h0000_0020, 32'h0000_0040, S_SHL, 16'h0020);

        // NOP: silent T3 then back to T0
        applyStimulus("nop", 32'hD000_0000);
        stepCheck("nop.T3", 32'h0, 16'h0, 15'h0);

        // SUB R4,R5,R6 with Run dropped mid-instruction
        stepCheck("sub.T0", 32'h0010_0000, 16'h0, S_INCPC | S_ZLOIN);
        Run = 1'b0;
        stepCheck("sub.T1", 32'h0008_0000, 16'h0, S_PCIN | S_READ | S_MDRIN);
        stepCheck("sub.T2", 32'h0020_0000, 16'h0, 15'h0);
        busMuxOut = 32'h222B_0000;
        stepCheck("sub.T3", 32'h0000_0020, 16'h0, S_YIN);
        stepCheck("sub.T4", 32'h0000_0040, 16'h0, S_SUB | S_ZLOIN);
        stepCheck("sub.T5", 32'h0008_0000, 16'h0010, 15'h0);
        stepCheck("idle1", 32'h0, 16'h0, 15'h0);
        stepCheck("idle2", 32'h0, 16'h0, 15'h0);
        Run = 1'b1;

        // ADD R0,R1,R2: R0 write depends on the zero-register option
        runAlu3("addr0", 32'h1809_0000, 32'h0000_0002, 32'h0000_0004, S_ADD, RIN_R0);

        // Clear during T4 drops the strobes immediately
        applyStimulus("clr", 32'h1989_0000);
        stepCheck("clr.T3", 32'h0000_0002, 16'h0, S_YIN);
        stepCheck("clr.T4", 32'h0000_0004, 16'h0, S_ADD | S_ZLOIN);
        #2 Clear = 1'b0;
        #1 expectCycle("clr.async", 32'h0, 16'h0, 15'h0);
        @(negedge Clock);
        Run   = 1'b0;
        Clear = 1'b1;
        stepCheck("clr.idle", 32'h0, 16'h0, 15'h0);
        Run = 1'b1;

        // HALT holds with Run high until Clear
        applyStimulus("halt", 32'hD800_0000);
        stepCheck("halt.T3", 32'h0, 16'h0, 15'h0);
        for (int i = 0; i < 10; i++) begin
            stepCheck($sformatf("halt.c%0d", i), 32'h0, 16'h0, S_HALT);
        end
        #2 Clear = 1'b0;
        #1 expectCycle("halt.clear", 32'h0, 16'h0, 15'h0);
        @(negedge Clock);
        Clear = 1'b1;
        stepCheck("restart.T0", 32'h0010_0000, 16'h0, S_INCPC | S_ZLOIN);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
